icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache that answers the instruction fetch unit's address with an instruction and a one-bit ready. On a miss it issues a single-word read to the memory controller over a valid/ready handshake, fills the line, then serves the fetch as a hit. It sits between instruction fetch and the memory controller and keeps answering in-flight requests correctly across pc redirects.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/icache_array.sv | 52 +++++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-side memory blocks.
//   INDEX_BITS  default line-index width (2^INDEX_BITS lines)
//   TAG_BITS    tag width left over from a 30-bit word address
//   WORD_ALIGN  low address bits of a word-aligned request
//   state_e     instruction cache controller states
package cpu_pkg;

  localparam int unsigned INDEX_BITS = 6;
  localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  typedef enum logic {
    IDLE,
    MISS
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk_in, rst_in         clock and synchronous active-high reset (clears valid bits only)
//   rd_index               asynchronous read index
//   rd_valid/tag/data      contents of line rd_index
//   we, wr_index,
//   wr_tag, wr_data        synchronous write; sets the line valid
module icache_array
  import cpu_pkg::*;
#(
  parameter int unsigned INDEX_BITS = cpu_pkg::INDEX_BITS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [INDEX_BITS-1:0]    rd_index,
  output logic                     rd_valid,
  output logic [29-INDEX_BITS:0]   rd_tag,
  output logic [31:0]              rd_data,
  input  logic                     we,
  input  logic [INDEX_BITS-1:0]    wr_index,
  input  logic [29-INDEX_BITS:0]   wr_tag,
  input  logic [31:0]              wr_data
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned Depth    = 1 << INDEX_BITS;

  logic [Depth-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [Depth];
  logic [31:0]         data_q [Depth];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global ready; low freezes all state
//   fetch_valid, fetch_addr   fetch request (bits [1:0] ignored)
//   flush                     pc redirect; abandons the current requester
//   fetch_ready, fetch_inst   same-cycle hit response
//   mem_valid, mem_addr       registered single-word read request
//   mem_ready, mem_data       read completion and returned word
module icache
  import cpu_pkg::*;
#(
  parameter int unsigned INDEX_BITS = cpu_pkg::INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  state_e state_q, state_d;
  logic [31:0] miss_addr_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  start_miss;
  logic                  fill;
  logic                  unused_addr_bits;

  assign index            = fetch_addr[INDEX_BITS+1:2];
  assign tag              = fetch_addr[31:INDEX_BITS+2];
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign hit        = fetch_valid & rd_valid & (rd_tag == tag);
  assign start_miss = (state_q == IDLE) & fetch_valid & ~hit & ~flush & rdy_in;
  // A flush never cancels the fill: the returned word is correct for miss_addr_q.
  assign fill       = (state_q == MISS) & mem_ready & rdy_in & ~rst_in;

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill),
    .wr_index (miss_addr_q[INDEX_BITS+1:2]),
    .wr_tag   (miss_addr_q[31:INDEX_BITS+2]),
    .wr_data  (mem_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      miss_addr_q <= '0;
    end else if (start_miss) begin
      miss_addr_q <= {fetch_addr[31:2], WORD_ALIGN};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_miss) state_d = MISS;
      MISS:    if (mem_ready && rdy_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_valid comes straight from the state flop and mem_addr from miss_addr_q,
  // so both are registered and stay put until the cycle after mem_ready.
  always_comb begin
    fetch_ready = ~rst_in & rdy_in & ~flush & (state_q == IDLE) & hit;
    fetch_inst  = fetch_ready ? rd_data : 32'h0;
    mem_valid   = (state_q == MISS);
    mem_addr    = miss_addr_q;
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam int unsigned IB = 6;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  always #5 clk_in = ~clk_in;

  icache #(
    .INDEX_BITS(IB)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_ready (fetch_ready),
    .fetch_inst  (fetch_inst),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_mem_q[$];

  // Reference model: which word address each line currently holds.
  bit          m_valid   [1 << IB];
  logic [29:0] line_addr [1 << IB];

  int unsigned mem_lat = 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[IB+1:2]] && (line_addr[a[IB+1:2]] == a[31:2]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[a[IB+1:2]]   = 1'b1;
    line_addr[a[IB+1:2]] = a[31:2];
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << IB); i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory controller: answers mem_lat cycles after the request first appears.
  initial begin
    int unsigned cnt;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!mem_valid) begin
        cnt       = 0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (cnt >= mem_lat - 1);
        cnt++;
      end
      mem_data = mem_ready ? mem_fn(mem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: pops expected words on fetch_ready and expected addresses on new requests.
  logic        prev_mv = 1'b0;
  logic [31:0] prev_ma = 32'h0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (fetch_ready) begin
        check("ready_needs_valid", 32'(fetch_valid), 32'd1);
        if (exp_inst_q.size() == 0) fail_now("unexpected_fetch_ready");
        else check("fetch_inst", fetch_inst, exp_inst_q.pop_front());
      end
      if (mem_valid && !prev_mv) begin
        if (exp_mem_q.size() == 0) fail_now("unexpected_mem_request");
        else check("mem_addr", mem_addr, exp_mem_q.pop_front());
      end else if (mem_valid && prev_mv) begin
        check("mem_addr_hold", mem_addr, prev_ma);
      end
      prev_mv = mem_valid;
      prev_ma = mem_addr;
    end
  end

  // Issue one fetch and hold it until served. Starts and ends at posedge+1.
  task automatic do_fetch(input logic [31:0] a, input bit check_lat);
    bit          h;
    int          n;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    h  = model_hit(wa);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    flush       = 1'b0;
    exp_inst_q.push_back(mem_fn(wa));
    if (!h) exp_mem_q.push_back(wa);
    @(negedge clk_in);
    check("hit_same_cycle", 32'(fetch_ready), 32'(h));
    n = 0;
    while (!fetch_ready && n < 100) begin
      @(negedge clk_in);
      n++;
      if (!h && n == 1) check("mem_valid_t1", 32'(mem_valid), 32'd1);
    end
    if (!fetch_ready) begin
      fail_now("fetch_timeout");
      exp_inst_q.delete();
      exp_mem_q.delete();
    end else if (!h && check_lat) begin
      check("miss_latency", 32'(n), 32'(mem_lat + 1));
    end
    model_fill(wa);
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_mem_idle();
    int n;
    n = 0;
    while (mem_valid && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (mem_valid) fail_now("mem_idle_timeout");
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa [2];
    logic [31:0] fb [2];
    int unsigned fl [2];
    fa[0] = 32'h40; fb[0] = 32'h80; fl[0] = 5;
    fa[1] = 32'h44; fb[1] = 32'h84; fl[1] = 2;

    model_clear();
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h100;
    flush       = 1'b0;

    // Reset state, with a request present that must be ignored.
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_fetch_inst", fetch_inst, 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk_in);
    #1;
    fetch_valid = 1'b0;
    rst_in      = 1'b0;
    @(negedge clk_in);
    check("idle_mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk_in);
    #1;

    // Cold miss.
    mem_lat = 3;
    do_fetch(32'h100, 1'b1);

    // Hit stream.
    mem_lat = 2;
    do_fetch(32'h104, 1'b1);
    do_fetch(32'h108, 1'b1);
    do_fetch(32'h100, 1'b1);
    do_fetch(32'h104, 1'b1);
    do_fetch(32'h108, 1'b1);

    // Conflict on index 0.
    do_fetch(32'h200, 1'b1);
    do_fetch(32'h200, 1'b1);
    do_fetch(32'h100, 1'b1);

    // Flush during miss; the second variant lands the flush on the mem_ready cycle.
    for (int i = 0; i < 2; i++) begin
      mem_lat     = fl[i];
      fetch_valid = 1'b1;
      fetch_addr  = fa[i];
      exp_mem_q.push_back(fa[i]);
      @(negedge clk_in);
      check("flush_first_ready", 32'(fetch_ready), 32'd0);
      repeat (2) begin
        @(posedge clk_in);
        #1;
      end
      flush      = 1'b1;
      fetch_addr = fb[i];
      @(negedge clk_in);
      check("flush_ready", 32'(fetch_ready), 32'd0);
      @(posedge clk_in);
      #1;
      flush       = 1'b0;
      fetch_valid = 1'b0;
      wait_mem_idle();
      model_fill(fa[i]);
      do_fetch(fb[i], 1'b1);
      do_fetch(fa[i], 1'b1);
    end

    // rdy_in stall with mem_ready held high.
    mem_lat     = 1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h300;
    exp_inst_q.push_back(mem_fn(32'h300));
    exp_mem_q.push_back(32'h300);
    @(negedge clk_in);
    check("stall_first_ready", 32'(fetch_ready), 32'd0);
    repeat (4) begin
      @(posedge clk_in);
      #1;
      rdy_in = 1'b0;
      @(negedge clk_in);
      check("stall_ready", 32'(fetch_ready), 32'd0);
      check("stall_mem_valid", 32'(mem_valid), 32'd1);
      check("stall_mem_ready", 32'(mem_ready), 32'd1);
    end
    @(posedge clk_in);
    #1;
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("stall_complete_ready", 32'(fetch_ready), 32'd0);
    @(negedge clk_in);
    check("stall_served", 32'(fetch_ready), 32'd1);
    if (!fetch_ready) exp_inst_q.delete();
    model_fill(32'h300);
    @(posedge clk_in);
    #1;

    // Reset mid-miss.
    mem_lat = 2;
    do_fetch(32'h100, 1'b1);
    do_fetch(32'h100, 1'b1);
    mem_lat     = 10;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h1F0;
    exp_mem_q.push_back(32'h1F0);
    @(negedge clk_in);
    repeat (2) begin
      @(posedge clk_in);
      #1;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_fetch_ready", 32'(fetch_ready), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in      = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk_in);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    model_clear();
    @(posedge clk_in);
    #1;
    mem_lat = 2;
    do_fetch(32'h100, 1'b1);
    do_fetch(32'h1F0, 1'b1);

    // Random traffic over a small address pool for hits and conflicts.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      mem_lat = $urandom_range(1, 4);
      do_fetch(a, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        fetch_valid = 1'b0;
        fetch_addr  = $urandom;
        @(posedge clk_in);
        #1;
      end
    end

    fetch_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    if (exp_inst_q.size() != 0 || exp_mem_q.size() != 0) fail_now("scoreboard_not_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
